// File: rtl/psk_burst_scheduler_if.sv
// Control-side bundle of the PSK burst scheduler: burst settings and start request in,
// impulse strobes, gate, phase code and burst status out.
interface psk_burst_scheduler_if;
    logic        SIGN_START_GEN;
    logic [9:0]  T_IMPULSE;
    logic [12:0] T_PERIOD;
    logic [4:0]  NUM_OF_IMP;
    logic [15:0] T_CHIP;
    logic        SIGN_START_CALC;
    logic        SIGN_STOP_CALC;
    logic        GATE;
    logic        PHASE_FLIP;
    logic [4:0]  IMP_INDEX;
    logic        BUSY;
    logic        DONE;

    modport master (
        output SIGN_START_GEN, T_IMPULSE, T_PERIOD, NUM_OF_IMP, T_CHIP,
        input  SIGN_START_CALC, SIGN_STOP_CALC, GATE, PHASE_FLIP, IMP_INDEX, BUSY, DONE
    );

    modport slave (
        input  SIGN_START_GEN, T_IMPULSE, T_PERIOD, NUM_OF_IMP, T_CHIP,
        output SIGN_START_CALC, SIGN_STOP_CALC, GATE, PHASE_FLIP, IMP_INDEX, BUSY, DONE
    );
endinterface

// File: rtl/psk_burst_scheduler.sv
// Burst sequencer for the PSK impulse generator: turns a start edge plus latched
// impulse-train settings into gate/strobe timing and a per-chip binary phase code.
module psk_burst_scheduler #(
    parameter int                  CLK_PER_US = 500,
    parameter int                  CODE_LEN   = 13,
    parameter logic [CODE_LEN-1:0] CODE       = 13'b1111100110101
) (
    input  logic                 CLK,
    input  logic                 RESET,
    psk_burst_scheduler_if.slave bus
);
    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_ON       = 2'd1;
    localparam logic [1:0]  S_OFF      = 2'd2;
    localparam logic [15:0] PRESC_LAST = 16'(CLK_PER_US - 1);
    localparam logic [4:0]  CHIP_LAST  = 5'(CODE_LEN - 1);

    // Code re-ordered so that bit j holds the value of chip j.
    logic [31:0] chipTable;
    for (genvar g = 0; g < 32; g++) begin : gChip
        if (g < CODE_LEN) begin : gUsed
            assign chipTable[g] = CODE[CODE_LEN-1-g];
        end else begin : gPad
            assign chipTable[g] = 1'b0;
        end
    end

    logic [1:0]  state_q, state_d;
    logic        startPrev_q, armed_q;
    logic [15:0] presc_q, presc_d;
    logic [13:0] usCnt_q, usCnt_d;
    logic [15:0] chipCyc_q, chipCyc_d;
    logic [4:0]  chipIdx_q, chipIdx_d;
    logic [13:0] impLastUs_q, impLastUs_d;
    logic [13:0] periodLastUs_q, periodLastUs_d;
    logic [4:0]  lastImp_q, lastImp_d;
    logic [15:0] tChip_q, tChip_d;
    logic        startCalc_q, startCalc_d;
    logic        stopCalc_q, stopCalc_d;
    logic        gate_q, gate_d;
    logic        phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  impIndex_q, impIndex_d;

    logic        startEdge, tickEnd, beginImpulse;
    logic [4:0]  chipNext;
    logic [13:0] teffUs;

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        usCnt_d        = usCnt_q;
        chipCyc_d      = chipCyc_q;
        chipIdx_d      = chipIdx_q;
        impLastUs_d    = impLastUs_q;
        periodLastUs_d = periodLastUs_q;
        lastImp_d      = lastImp_q;
        tChip_d        = tChip_q;
        startCalc_d    = 1'b0;
        stopCalc_d     = 1'b0;
        done_d         = 1'b0;
        gate_d         = gate_q;
        phase_d        = phase_q;
        busy_d         = busy_q;
        impIndex_d     = impIndex_q;
        beginImpulse   = 1'b0;

        startEdge = armed_q & bus.SIGN_START_GEN & ~startPrev_q;
        tickEnd   = (presc_q == PRESC_LAST);
        chipNext  = (chipIdx_q == CHIP_LAST) ? 5'd0 : chipIdx_q + 5'd1;
        teffUs    = ({1'b0, bus.T_PERIOD} > {4'd0, bus.T_IMPULSE})
                    ? {1'b0, bus.T_PERIOD} : {4'd0, bus.T_IMPULSE} + 14'd1;

        // The microsecond count runs from impulse start across both ON and OFF.
        if (state_q != S_IDLE) begin
            presc_d = tickEnd ? 16'd0 : presc_q + 16'd1;
            usCnt_d = tickEnd ? usCnt_q + 14'd1 : usCnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (startEdge && !done_q) begin
                    if (bus.NUM_OF_IMP == 5'd0 || bus.T_IMPULSE == 10'd0) begin
                        done_d = 1'b1;
                    end else begin
                        impLastUs_d    = {4'd0, bus.T_IMPULSE} - 14'd1;
                        periodLastUs_d = teffUs - 14'd1;
                        lastImp_d      = bus.NUM_OF_IMP - 5'd1;
                        tChip_d        = bus.T_CHIP;
                        busy_d         = 1'b1;
                        impIndex_d     = 5'd0;
                        beginImpulse   = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (tChip_q != 16'd0) begin
                    if (chipCyc_q == tChip_q - 16'd1) begin
                        chipCyc_d = 16'd0;
                        chipIdx_d = chipNext;
                        phase_d   = chipTable[chipNext];
                    end else begin
                        chipCyc_d = chipCyc_q + 16'd1;
                    end
                end
                if (tickEnd && usCnt_q == impLastUs_q) begin
                    gate_d     = 1'b0;
                    phase_d    = 1'b0;
                    stopCalc_d = 1'b1;
                    if (impIndex_q == lastImp_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_OFF;
                    end
                end
            end
            S_OFF: begin
                if (tickEnd && usCnt_q == periodLastUs_q) begin
                    impIndex_d   = impIndex_q + 5'd1;
                    beginImpulse = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every impulse restarts all counters so the period is exact in cycles.
        if (beginImpulse) begin
            state_d     = S_ON;
            gate_d      = 1'b1;
            startCalc_d = 1'b1;
            presc_d     = 16'd0;
            usCnt_d     = 14'd0;
            chipCyc_d   = 16'd0;
            chipIdx_d   = 5'd0;
            phase_d     = (tChip_d != 16'd0) & chipTable[0];
        end
    end

    // armed_q keeps a start input already high at reset release from counting as an edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q        <= S_IDLE;
            startPrev_q    <= 1'b0;
            armed_q        <= 1'b0;
            presc_q        <= 16'd0;
            usCnt_q        <= 14'd0;
            chipCyc_q      <= 16'd0;
            chipIdx_q      <= 5'd0;
            impLastUs_q    <= 14'd0;
            periodLastUs_q <= 14'd0;
            lastImp_q      <= 5'd0;
            tChip_q        <= 16'd0;
            startCalc_q    <= 1'b0;
            stopCalc_q     <= 1'b0;
            gate_q         <= 1'b0;
            phase_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            impIndex_q     <= 5'd0;
        end else begin
            state_q        <= state_d;
            startPrev_q    <= bus.SIGN_START_GEN;
            armed_q        <= 1'b1;
            presc_q        <= presc_d;
            usCnt_q        <= usCnt_d;
            chipCyc_q      <= chipCyc_d;
            chipIdx_q      <= chipIdx_d;
            impLastUs_q    <= impLastUs_d;
            periodLastUs_q <= periodLastUs_d;
            lastImp_q      <= lastImp_d;
            tChip_q        <= tChip_d;
            startCalc_q    <= startCalc_d;
            stopCalc_q     <= stopCalc_d;
            gate_q         <= gate_d;
            phase_q        <= phase_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            impIndex_q     <= impIndex_d;
        end
    end

    assign bus.SIGN_START_CALC = startCalc_q;
    assign bus.SIGN_STOP_CALC  = stopCalc_q;
    assign bus.GATE            = gate_q;
    assign bus.PHASE_FLIP      = phase_q;
    assign bus.IMP_INDEX       = impIndex_q;
    assign bus.BUSY            = busy_q;
    assign bus.DONE            = done_q;
endmodule

// File: tb/tb_psk_burst_scheduler.sv
// Self-checking bench for psk_burst_scheduler: table vectors, hand-written corner
// sequences and random bursts, all compared cycle by cycle against an arithmetic model.
module tb_psk_burst_scheduler;
    localparam int          CPU      = 4;
    localparam int          CODE_LEN = 13;
    localparam logic [12:0] CODE_TB  = 13'b1111100110101;

    typedef struct packed {
        logic [9:0]  timp;
        logic [12:0] tper;
        logic [4:0]  num;
        logic [15:0] tchip;
    } cfg_t;

    typedef struct packed {
        logic       startCalc;
        logic       stopCalc;
        logic       gate;
        logic       phase;
        logic       busy;
        logic       done;
        logic [4:0] idx;
    } outs_t;

    typedef struct {
        cfg_t cfg;
        int   expDone;
        int   expGate;
        int   expStarts;
    } vec_t;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    logic [4:0] holdIdx;

    psk_burst_scheduler_if bus ();

    psk_burst_scheduler #(.CLK_PER_US(CPU), .CODE_LEN(CODE_LEN), .CODE(CODE_TB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t getOuts();
        outs_t o;
        o.startCalc = bus.SIGN_START_CALC;
        o.stopCalc  = bus.SIGN_STOP_CALC;
        o.gate      = bus.GATE;
        o.phase     = bus.PHASE_FLIP;
        o.busy      = bus.BUSY;
        o.done      = bus.DONE;
        o.idx       = bus.IMP_INDEX;
        return o;
    endfunction

    function automatic int expDoneOf(input cfg_t c);
        int teff;
        if (c.num == 0 || c.timp == 0) return 1;
        teff = (c.tper > c.timp) ? int'(c.tper) : int'(c.timp) + 1;
        return 1 + (int'(c.num) - 1) * teff * CPU + int'(c.timp) * CPU;
    endfunction

    // Expected outputs t cycles after the cycle in which the start input rose.
    function automatic outs_t modelAt(input cfg_t c, input int t, input logic [4:0] hold);
        outs_t       o;
        int          len, per, teff, k, r, endT, chip;
        logic [12:0] sh;
        o     = '0;
        o.idx = hold;
        if (c.num == 0 || c.timp == 0) begin
            o.done = (t == 1);
            return o;
        end
        if (t < 1) return o;
        teff = (c.tper > c.timp) ? int'(c.tper) : int'(c.timp) + 1;
        len  = int'(c.timp) * CPU;
        per  = teff * CPU;
        endT = expDoneOf(c);
        if (t >= endT) begin
            o.idx      = c.num - 5'd1;
            o.stopCalc = (t == endT);
            o.done     = (t == endT);
            return o;
        end
        k           = (t - 1) / per;
        r           = (t - 1) % per;
        o.busy      = 1'b1;
        o.idx       = 5'(k);
        o.gate      = (r < len);
        o.startCalc = (r == 0);
        o.stopCalc  = (r == len);
        if (o.gate && c.tchip != 0) begin
            chip    = (r / int'(c.tchip)) % CODE_LEN;
            sh      = CODE_TB >> (CODE_LEN - 1 - chip);
            o.phase = sh[0];
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Raises start in the current cycle (cycle 0), then compares cycles 1..nCycles to the model.
    task automatic applyStimulus(input cfg_t c, input int nCycles, input int glitchA, input int glitchB,
                                 output int doneAt, output int gateCnt, output int startCnt,
                                 output int doneCnt, output logic [63:0] phaseHist);
        outs_t got, exp;
        doneAt    = 0;
        gateCnt   = 0;
        startCnt  = 0;
        doneCnt   = 0;
        phaseHist = '0;
        bus.T_IMPULSE      = c.timp;
        bus.T_PERIOD       = c.tper;
        bus.NUM_OF_IMP     = c.num;
        bus.T_CHIP         = c.tchip;
        bus.SIGN_START_GEN = 1'b1;
        for (int t = 1; t <= nCycles; t++) begin
            @(posedge CLK);
            #1;
            if (t == 1 || t == glitchA + 1 || t == glitchB + 1) bus.SIGN_START_GEN = 1'b0;
            if (t == glitchA || t == glitchB) begin
                bus.SIGN_START_GEN = 1'b1;
                bus.T_IMPULSE      = 10'd7;
                bus.T_PERIOD       = 13'd1;
                bus.NUM_OF_IMP     = 5'd9;
                bus.T_CHIP         = 16'd3;
            end
            got = getOuts();
            exp = modelAt(c, t, holdIdx);
            checkOutput($sformatf("trace t=%0d", t), {21'd0, got}, {21'd0, exp});
            if (got.gate) gateCnt++;
            if (got.startCalc) startCnt++;
            if (got.done) begin
                doneCnt++;
                if (doneAt == 0) doneAt = t;
            end
            if (t < 64) phaseHist[t] = got.phase;
        end
        if (c.num != 0 && c.timp != 0) holdIdx = c.num - 5'd1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    vec_t        vecs[7];
    cfg_t        cfg1;
    cfg_t        rc;
    int          dAt, gCnt, sCnt, dCnt;
    logic [63:0] pHist;
    logic [15:0] gotPhase;
    logic [15:0] expPhase;
    outs_t       o;

    initial begin
        checks  = 0;
        errors  = 0;
        holdIdx = 5'd0;
        cfg1    = '{timp: 10'd3, tper: 13'd5, num: 5'd2, tchip: 16'd0};

        vecs[0] = '{cfg1, 33, 24, 2};
        vecs[1] = '{'{timp: 10'd10, tper: 13'd2, num: 5'd2, tchip: 16'd0}, 85, 80, 2};
        vecs[2] = '{'{timp: 10'd3, tper: 13'd5, num: 5'd0, tchip: 16'd0}, 1, 0, 0};
        vecs[3] = '{'{timp: 10'd0, tper: 13'd5, num: 5'd2, tchip: 16'd0}, 1, 0, 0};
        vecs[4] = '{'{timp: 10'd4, tper: 13'd6, num: 5'd1, tchip: 16'd1}, 17, 16, 1};
        vecs[5] = '{'{timp: 10'd1, tper: 13'd1, num: 5'd3, tchip: 16'd2}, 21, 12, 3};
        vecs[6] = '{'{timp: 10'd2, tper: 13'd3, num: 5'd1, tchip: 16'd3}, 9, 8, 1};

        // Reset values, and a start input already high when reset is released.
        RESET              = 1'b0;
        bus.SIGN_START_GEN = 1'b1;
        bus.T_IMPULSE      = 10'd3;
        bus.T_PERIOD       = 13'd5;
        bus.NUM_OF_IMP     = 5'd2;
        bus.T_CHIP         = 16'd0;
        waitCycles(3);
        checkOutput("reset outputs", {21'd0, getOuts()}, 32'd0);
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            waitCycles(1);
            checkOutput($sformatf("held start %0d", i), {21'd0, getOuts()}, 32'd0);
        end
        bus.SIGN_START_GEN = 1'b0;
        waitCycles(2);

        // Table-driven bursts.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].cfg, vecs[v].expDone + 2, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
            checkOutput($sformatf("vec%0d done cycle", v), 32'(dAt), 32'(vecs[v].expDone));
            checkOutput($sformatf("vec%0d gate cycles", v), 32'(gCnt), 32'(vecs[v].expGate));
            checkOutput($sformatf("vec%0d start strobes", v), 32'(sCnt), 32'(vecs[v].expStarts));
        end

        // Barker-13 chip sequence with one-cycle chips, then unmodulated.
        applyStimulus('{timp: 10'd4, tper: 13'd6, num: 5'd1, tchip: 16'd1}, 19, -10, -10,
                      dAt, gCnt, sCnt, dCnt, pHist);
        for (int t = 1; t <= 16; t++) gotPhase[16-t] = pHist[t];
        expPhase = 16'b1111100110101111;
        checkOutput("phase sequence", {16'd0, gotPhase}, {16'd0, expPhase});
        applyStimulus('{timp: 10'd4, tper: 13'd6, num: 5'd1, tchip: 16'd0}, 19, -10, -10,
                      dAt, gCnt, sCnt, dCnt, pHist);
        checkOutput("phase unmodulated", pHist[31:0], 32'd0);

        // Start edges and config changes mid-burst are ignored.
        applyStimulus(cfg1, 40, 5, 15, dAt, gCnt, sCnt, dCnt, pHist);
        checkOutput("glitch done count", 32'(dCnt), 32'd1);
        checkOutput("glitch done cycle", 32'(dAt), 32'd33);

        // A start edge on the DONE cycle is dropped.
        applyStimulus(cfg1, 33, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
        bus.SIGN_START_GEN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitCycles(1);
            bus.SIGN_START_GEN = 1'b0;
            o = getOuts();
            checkOutput($sformatf("start on done ignored %0d", i), {30'd0, o.gate, o.busy}, 32'd0);
        end

        // The cycle right after DONE accepts a new start.
        applyStimulus(cfg1, 33, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
        waitCycles(1);
        applyStimulus(cfg1, 35, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
        checkOutput("start after done", 32'(dAt), 32'd33);

        // Asynchronous reset in the middle of the first impulse.
        bus.T_IMPULSE      = cfg1.timp;
        bus.T_PERIOD       = cfg1.tper;
        bus.NUM_OF_IMP     = cfg1.num;
        bus.T_CHIP         = cfg1.tchip;
        bus.SIGN_START_GEN = 1'b1;
        waitCycles(1);
        bus.SIGN_START_GEN = 1'b0;
        waitCycles(6);
        o = getOuts();
        checkOutput("gate before reset", {31'd0, o.gate}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("async reset outputs", {21'd0, getOuts()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput($sformatf("in reset %0d", i), {21'd0, getOuts()}, 32'd0);
        end
        RESET   = 1'b1;
        holdIdx = 5'd0;
        waitCycles(2);
        applyStimulus(cfg1, 35, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
        checkOutput("post reset done cycle", 32'(dAt), 32'd33);

        // Random bursts against the model.
        for (int n = 0; n < 10; n++) begin
            rc.timp  = 10'($urandom_range(0, 4));
            rc.tper  = 13'($urandom_range(0, 8));
            rc.num   = 5'($urandom_range(0, 3));
            rc.tchip = 16'($urandom_range(0, 5));
            applyStimulus(rc, expDoneOf(rc) + 2, -10, -10, dAt, gCnt, sCnt, dCnt, pHist);
            checkOutput($sformatf("random%0d done count", n), 32'(dCnt), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psk_burst_scheduler.md
# psk_burst_scheduler

Sequencer for the PSK impulse generator. It turns a start request and the impulse-train settings (impulse length, repetition period, impulse count) into cycle-accurate start/stop strobes and a gate for the phase accumulator and output register. It also applies a binary phase code, one chip per programmable interval, during each impulse. It sits between the control/configuration logic and the PSK phase accumulator.

## Interface
- CLK_PER_US, 500: CLK cycles per microsecond (500 MHz clock); range 2..65535.
- CODE_LEN, 13: number of phase-code chips; range 1..32.
- CODE, 13'b1111100110101: phase code (Barker-13). MSB is chip 0; 1 = 180° flip.
- CLK  in  1: system clock; all logic on its rising edge.
- RESET  in  1: asynchronous, active-low reset.
- SIGN_START_GEN  in  1: start request; a rising edge (registered) starts one burst.
- T_IMPULSE  in  10: impulse length in µs.
- T_PERIOD  in  13: repetition period in µs.
- NUM_OF_IMP  in  5: impulses per burst.
- T_CHIP  in  16: chip length in CLK cycles; 0 means unmodulated.
- SIGN_START_CALC  out  1: one-cycle strobe on the first gate cycle of each impulse.
- SIGN_STOP_CALC  out  1: one-cycle strobe on the cycle after the last gate cycle.
- GATE  out  1: high while an impulse is being generated.
- PHASE_FLIP  out  1: current chip value; 0 whenever GATE is 0.
- IMP_INDEX  out  5: index of the current or last impulse, 0-based.
- BUSY  out  1: burst in progress.
- DONE  out  1: one-cycle strobe at burst end.

## Operation
- States: IDLE, ON, OFF.
- Configuration is latched on the accepted start edge. Input changes during a burst have no effect.
- IDLE:
  - Start edge with NUM_OF_IMP=0 or T_IMPULSE=0: DONE pulses next cycle, no strobes, stay IDLE.
  - Otherwise: go to ON, BUSY=1, IMP_INDEX=0.
- ON:
  - Lasts T_IMPULSE×CLK_PER_US cycles with GATE=1.
  - Then goes to OFF, or ends the burst if this was the last impulse.
- OFF:
  - Lasts (Teff−T_IMPULSE)×CLK_PER_US cycles, with Teff = T_PERIOD if T_PERIOD > T_IMPULSE, else T_IMPULSE+1 (minimum 1 µs off time).
  - Then IMP_INDEX increments and the block returns to ON.
- Burst end: no trailing OFF after the last impulse. SIGN_STOP_CALC and DONE pulse together, BUSY falls the same cycle, state returns to IDLE, IMP_INDEX holds its last value.
- Counters:
  - Prescaler 0..CLK_PER_US−1, plus a µs counter sized for 8191+1.
  - Both clear on each impulse start, so the period is exact in cycles: Teff×CLK_PER_US.
- Phase code:
  - Chip counter clears at each impulse start and advances every T_CHIP cycles.
  - Chip index wraps CODE_LEN−1 → 0.
  - PHASE_FLIP = CODE[CODE_LEN−1−chip] while GATE=1.
  - T_CHIP=0 forces PHASE_FLIP=0.
- Start edges while BUSY are ignored and not queued.
- A RESET assertion mid-burst aborts immediately: all outputs go to 0 and state goes to IDLE. No DONE is issued.
- Reset values: all outputs 0, state IDLE, edge-detect register 0. A start input held high at reset release does not start a burst.

## Timing
- Start edge registered at cycle 0 → SIGN_START_CALC and GATE rise at cycle 1.
- Impulse k starts at cycle 1 + k×Teff×CLK_PER_US.
- GATE covers exactly T_IMPULSE×CLK_PER_US cycles.
- SIGN_STOP_CALC is on the first cycle with GATE=0; DONE is on the same cycle as the final SIGN_STOP_CALC.
- PHASE_FLIP changes on the same edge as the chip boundary: chip j covers gate cycles j×T_CHIP .. (j+1)×T_CHIP−1, relative to impulse start.
- All outputs are registered. A start edge on the DONE cycle is ignored; the earliest accepted start is the cycle after DONE.

## Test plan
- CLK_PER_US=4, T_IMPULSE=3, T_PERIOD=5, NUM_OF_IMP=2, start at cycle 0:
  - START_CALC at cycles 1 and 21.
  - GATE over cycles 1–12 and 21–32.
  - STOP_CALC at 13 and 33; DONE at 33; BUSY over 1–32.
  - IMP_INDEX becomes 1 at cycle 21.
- T_IMPULSE=10, T_PERIOD=2, NUM_OF_IMP=2, CLK_PER_US=4: Teff=11, second START_CALC at cycle 45, off gap of 4 cycles.
- NUM_OF_IMP=0 → DONE at cycle 1, no GATE. Separately, T_IMPULSE=0 → same result.
- T_CHIP=1, default CODE, T_IMPULSE=4, CLK_PER_US=4 (16 gate cycles):
  - PHASE_FLIP = 1,1,1,1,1,0,0,1,1,0,1,0,1 then wraps 1,1,1.
  - Re-run with T_CHIP=0 → PHASE_FLIP stays 0.
- Start edges at cycles 5 and 15 during a burst are ignored, giving one DONE only. A start edge on the cycle after DONE begins a new burst.
- RESET low at cycle 7 mid-impulse: all outputs 0 asynchronously, no DONE. After release, a new start behaves as in the first scenario.
